// File: rtl/fft_twiddle_seq.sv
// Twiddle-factor sequencer: walks stage/butterfly counters, addresses the twiddle ROMs and
// presents each twiddle on a valid/ready handshake. Define FFT_TW_CONJ_EN to add the inv port.
module fft_twiddle_seq #(
   parameter int LOG2N = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
`ifdef FFT_TW_CONJ_EN
   input  logic        inv,
`endif
   output logic        busy,
   output logic        done,
   output logic [4:0]  rom_addr,
   output logic        rom_en,
   input  logic [15:0] rom_re,
   input  logic [15:0] rom_im,
   output logic [15:0] tw_re,
   output logic [15:0] tw_im,
   output logic        tw_valid,
   input  logic        tw_ready,
   output logic [2:0]  tw_stage,
   output logic [3:0]  tw_bfly
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [2:0] S_LAST = 3'(LOG2N - 1);
   localparam logic [3:0] J_LAST = 4'((1 << (LOG2N - 1)) - 1);

`ifdef FFT_TW_CONJ_EN
   // The most negative input has no positive counterpart, so it saturates.
   function automatic logic [15:0] neg_sat(input logic [15:0] v);
      if (v == 16'h8000) begin
         neg_sat = 16'h7FFF;
      end else begin
         neg_sat = ~v + 16'h0001;
      end
   endfunction
`endif

   state_t      state_q, state_d;
   logic [2:0]  s_q, s_d;
   logic [3:0]  j_q, j_d;
   logic        tw_valid_q, tw_valid_d;
   logic [2:0]  tw_stage_q, tw_stage_d;
   logic [3:0]  tw_bfly_q, tw_bfly_d;
   logic        inv_q, inv_d;
   logic        issue_s;
   logic        accept_s;
   logic [4:0]  mask_s;
   logic [2:0]  shift_s;

   // Next-state, counter and handshake logic.
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      j_d        = j_q;
      tw_stage_d = tw_stage_q;
      tw_bfly_d  = tw_bfly_q;
      inv_d      = inv_q;
      issue_s    = (state_q == ST_RUN) && (!tw_valid_q || tw_ready);
      accept_s   = tw_valid_q && tw_ready;
      tw_valid_d = issue_s || (tw_valid_q && !tw_ready);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
`ifdef FFT_TW_CONJ_EN
               inv_d   = inv;
`else
               inv_d   = 1'b0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (issue_s) begin
               tw_stage_d = s_q;
               tw_bfly_d  = j_q;
               if (j_q == J_LAST) begin
                  j_d = 4'd0;
                  if (s_q == S_LAST) begin
                     s_d     = 3'd0;
                     state_d = ST_DRAIN;
                  end else begin
                     s_d = s_q + 3'd1;
                  end
               end else begin
                  j_d = j_q + 4'd1;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (accept_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ROM addressing: low s bits of j, left-justified within the LOG2N-1 address bits.
   always_comb begin
      mask_s   = (5'd1 << s_q) - 5'd1;
      shift_s  = S_LAST - s_q;
      rom_addr = ({1'b0, j_q} & mask_s) << shift_s;
      rom_en   = issue_s;
   end

   // Output decode; twiddle data comes straight from the registered ROM output.
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DRAIN) && accept_s;
      tw_valid = tw_valid_q;
      tw_stage = tw_stage_q;
      tw_bfly  = tw_bfly_q;
      tw_re    = rom_re;
`ifdef FFT_TW_CONJ_EN
      if (inv_q) begin
         tw_im = neg_sat(rom_im);
      end else begin
         tw_im = rom_im;
      end
`else
      tw_im    = rom_im;
`endif
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         s_q        <= 3'd0;
         j_q        <= 4'd0;
         tw_valid_q <= 1'b0;
         tw_stage_q <= 3'd0;
         tw_bfly_q  <= 4'd0;
         inv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         j_q        <= j_d;
         tw_valid_q <= tw_valid_d;
         tw_stage_q <= tw_stage_d;
         tw_bfly_q  <= tw_bfly_d;
         inv_q      <= inv_d;
      end
   end

endmodule

// File: doc/fft_twiddle_seq.md
FFT_TWIDDLE_SEQ -- requirements
Module: fft_twiddle_seq

Interface
REQ-001 Parameter: LOG2N, default 5, FFT size exponent (N = 2^LOG2N), legal range 2..5.
REQ-002 Port: clk  input  1  single clock, all logic rising-edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: start  input  1  one-cycle request to begin a twiddle sequence.
REQ-005 Port: busy  output  1  high from accepted start until done.
REQ-006 Port: done  output  1  one-cycle pulse after the last twiddle is accepted.
REQ-007 Port: rom_addr  output  5  address to real and imaginary twiddle ROMs.
REQ-008 Port: rom_en  output  1  ROM read enable; ROM data registered, 1-cycle latency, held while rom_en low.
REQ-009 Port: rom_re / rom_im  input  16 each  registered ROM read data.
REQ-010 Port: tw_re / tw_im  output  16 each  twiddle to butterfly, valid when tw_valid high.
REQ-011 Port: tw_valid  output  1  twiddle present; tw_ready  input  1  butterfly accepts.
REQ-012 Port: tw_stage  output  3  stage tag; tw_bfly  output  4  butterfly index tag.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-014 IDLE->RUN on start; start SHALL be ignored in RUN and DRAIN.
REQ-015 Issue SHALL occur in RUN when (!tw_valid || tw_ready); rom_en SHALL equal the issue condition.
REQ-016 Counters: stage s 0..LOG2N-1 (outer), butterfly j 0..2^(LOG2N-1)-1 (inner), both advancing only on issue.
REQ-017 rom_addr SHALL equal (j AND (2^s - 1)) shifted left by (LOG2N-1-s), zero-extended to 5 bits.
REQ-018 On issue, s and j SHALL be registered into tw_stage/tw_bfly; tw_valid SHALL rise the following cycle.
REQ-019 tw_valid next = issue OR (tw_valid AND NOT tw_ready).
REQ-020 tw_re SHALL pass rom_re directly; tw_im SHALL pass rom_im directly (see REQ-029).
REQ-021 While tw_valid AND NOT tw_ready, rom_en, rom_addr, tw_* SHALL hold stable.
REQ-022 Throughput SHALL be one twiddle per cycle with tw_ready held high; total N/2*LOG2N twiddles (80 at LOG2N=5).
REQ-023 Issue of last twiddle (s=LOG2N-1, j=max) SHALL move RUN->DRAIN.
REQ-024 DRAIN->IDLE when tw_valid AND tw_ready; done SHALL pulse that same cycle.
REQ-025 busy SHALL be high in RUN and DRAIN, low in IDLE; done never high in IDLE except on the DRAIN exit cycle.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, s=0, j=0, rom_addr=0, rom_en=0, tw_valid=0, tw_stage=0, tw_bfly=0, busy=0, done=0.
REQ-027 Reset mid-sequence SHALL abort immediately; no done pulse, no further tw_valid.
REQ-028 start coincident with rst_n low SHALL be ignored.

Configuration
REQ-029 Macro FFT_TW_CONJ_EN defined: input port inv (1 bit) exists, sampled on accepted start; when set, tw_im = two's-complement negation of rom_im, with 16'h8000 mapping to 16'h7FFF; reset clears the sampled inv.
REQ-030 FFT_TW_CONJ_EN undefined: no inv port; tw_im = rom_im always.

Verification
REQ-031 start pulse, tw_ready=1, LOG2N=5 -> rom_addr stage0 all 0; stage4 sequence 0,1,...,15; 80 tw_valid cycles consecutive; done at cycle of 80th acceptance.
REQ-032 Stage 3, j=5 -> rom_addr=10; stage 2, j=7 -> rom_addr=12; ROM with addr 1 data 16'h8be9 -> tw_im=16'h8be9 tagged with its stage/bfly.
REQ-033 tw_ready low for 4 cycles mid-stage-2 -> rom_en low, tw_* and tags frozen, no twiddle lost or duplicated; 80 total accepted.
REQ-034 rst_n low at 30th twiddle -> next cycle busy=0, tw_valid=0, rom_en=0; no done; new start runs full 80.
REQ-035 start asserted while busy -> ignored, sequence unchanged; start in same cycle as done -> ignored, IDLE next.
REQ-036 FFT_TW_CONJ_EN with inv=1: rom_im=16'h6ead -> tw_im=16'h9153; rom_im=16'h8000 -> 16'h7FFF; inv=0 -> pass-through.
